avalon_frame_reader: RTL and testbench

//  Avalon-MM read master that sits upstream of the SRAM Avalon slave and fetches a frame of 16-bit pixels.

---
 rtl/avalon_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_avalon_frame_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_frame_reader.sv
// avalon_frame_reader
//   Avalon-MM read master that fetches one frame of 16-bit pixels starting at
//   a programmed word address, buffers the returned words in a show-ahead
//   FIFO and presents them as a valid/ready stream with SOF/EOF markers.
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   start, frame_base  : frame request pulse and first word address
//   busy, done         : frame in progress / one-cycle completion pulse
//   read_n, write_n, address, byteEnable_n, waitrequest,
//   readdatavalid, readData : Avalon-MM master interface (read only)
//   pix_data, pix_valid, pix_ready, pix_sof, pix_eof : pixel stream
//   err_overflow       : sticky unexpected or overflowing return
module avalon_frame_reader #(
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              done,
  output logic              read_n,
  output logic              write_n,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        byteEnable_n,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  input  logic [15:0]       readData,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              err_overflow
);

  localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     accepted_q, accepted_d;
  logic [PW:0]       outst_q, outst_d;
  logic [PW:0]       fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic [15:0]       fifo_mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, pop, push, rtn_ok, rd_req, issue, credit_ok;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pix_valid  = !fifo_empty;
  assign pop        = pix_valid & pix_ready;
  assign pix_data   = fifo_mem_q[rd_ptr_q];
  assign pix_sof    = pix_valid & (accepted_q == '0);
  assign pix_eof    = pix_valid & (accepted_q == CW'(FRAME_WORDS - 1));

  // Words in flight plus words buffered never exceed the FIFO size. The sum
  // cannot grow without an issue, so a request raised under a stall stays
  // raised until the slave takes it.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (PW+2)'(FIFO_DEPTH);
  assign rd_req    = (state_q == S_ISSUE) & credit_ok;
  assign issue     = rd_req & !waitrequest;

  // A return with nothing outstanding is dropped without touching the count;
  // a return into a full FIFO is only legal if the head leaves the same cycle.
  assign rtn_ok = readdatavalid & (outst_q != '0);
  assign push   = rtn_ok & (!fifo_full | pop);

  assign read_n       = !rd_req;
  assign write_n      = 1'b1;
  assign byteEnable_n = 2'b00;
  assign address      = address_q;
  assign err_overflow = err_q;
  assign done         = (state_q == S_DRAIN) & (accepted_q == CW'(FRAME_WORDS));
  assign busy         = (state_q != S_IDLE) & !done;

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    issued_d   = issued_q;
    accepted_d = accepted_q + CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          address_d  = frame_base;
          issued_d   = '0;
          accepted_d = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          address_d = address_q + ADDR_W'(1);
          issued_d  = issued_q + CW'(1);
          if (issued_d == CW'(FRAME_WORDS)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outst_d    = outst_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;
    case ({issue, rtn_ok})
      2'b10:   outst_d = outst_q + (PW+1)'(1);
      2'b01:   outst_d = outst_q - (PW+1)'(1);
      default: outst_d = outst_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (PW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (PW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (readdatavalid & !push) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      address_q  <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= readData;
  end

endmodule

// File: tb/tb_avalon_frame_reader.sv
module tb_avalon_frame_reader;

  localparam int unsigned FW    = 12;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] frame_base = '0;
  logic        busy, done, read_n, write_n;
  logic [31:0] address;
  logic [1:0]  byteEnable_n;
  logic        waitrequest;
  logic        readdatavalid = 1'b0;
  logic [15:0] readData = '0;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eof, err_overflow;
  logic        pix_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  // Slave model controls.
  logic        ret_hold = 1'b0;
  logic        inject = 1'b0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  logic [15:0] rq[$];

  // Scoreboards: expected read addresses and expected {sof, eof, data}.
  logic [31:0] exp_addr[$];
  logic [17:0] exp_pix[$];
  int          iss_total = 0;
  int          done_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_saved = '0;

  always #5 clk = ~clk;

  avalon_frame_reader #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
    .busy(busy), .done(done), .read_n(read_n), .write_n(write_n),
    .address(address), .byteEnable_n(byteEnable_n), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .readData(readData),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .err_overflow(err_overflow)
  );

  function automatic logic [15:0] pix_of(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  assign waitrequest = rst && !read_n && (address == stall_addr) && (stall_left != 0);

  // Avalon slave: one-cycle read latency, optional return hold and stray return.
  always @(posedge clk) begin
    if (!rst) begin
      rq.delete();
      readdatavalid <= 1'b0;
    end else begin
      if (!read_n && !waitrequest) rq.push_back(pix_of(address));
      if (waitrequest) stall_left <= stall_left - 1;
      if (inject) begin
        readdatavalid <= 1'b1;
        readData      <= 16'hDEAD;
      end else if (!ret_hold && rq.size() > 0) begin
        readdatavalid <= 1'b1;
        readData      <= rq.pop_front();
      end else begin
        readdatavalid <= 1'b0;
      end
    end
  end

  // Monitor: checks every accepted read and every transferred pixel.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_read_n", {31'd0, read_n}, 32'd0);
        check("stall_hold_addr", address, stall_saved);
      end
      stall_prev  = waitrequest;
      stall_saved = address;
      if (!read_n && !waitrequest) begin
        iss_total++;
        if (exp_addr.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got read at 0x%0h, expected none", address);
        end else begin
          check("rd_addr", address, exp_addr.pop_front());
        end
      end
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) begin
          tests++; fails++;
          $display("FAIL pix_unexpected: got 0x%0h, expected none", pix_data);
        end else begin
          logic [17:0] e;
          e = exp_pix.pop_front();
          check("pix_data", {16'd0, pix_data}, {16'd0, e[15:0]});
          check("pix_sof", {31'd0, pix_sof}, {31'd0, e[17]});
          check("pix_eof", {31'd0, pix_eof}, {31'd0, e[16]});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_frame(input logic [31:0] base);
    for (int i = 0; i < int'(FW); i++) begin
      exp_addr.push_back(base + 32'(i));
      exp_pix.push_back({(i == 0), (i == int'(FW) - 1), pix_of(base + 32'(i))});
    end
    @(posedge clk); #1;
    frame_base = base;
    start = 1'b1;
    @(negedge clk);
    check("start_lat_pre", {31'd0, read_n}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    logic found;
    d0 = done_cnt;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    #1;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_n"}, {31'd0, read_n}, 32'd1);
    check({tag, "_address"}, address, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_sof"}, {31'd0, pix_sof}, 32'd0);
    check({tag, "_eof"}, {31'd0, pix_eof}, 32'd0);
    check({tag, "_err"}, {31'd0, err_overflow}, 32'd0);
  endtask

  initial begin
    int s;
    #1;
    check_reset_outputs("rst0");
    check("write_n", {31'd0, write_n}, 32'd1);
    check("byte_en_n", {30'd0, byteEnable_n}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: clean frame, back-to-back reads.
    s = iss_total;
    start_frame(32'h100);
    for (int i = 0; i < int'(FW); i++) begin
      @(negedge clk);
      check("b2b_read_n", {31'd0, read_n}, 32'd0);
    end
    wait_done("t1_done");
    #1;
    check("t1_issued", 32'(iss_total - s), 32'(FW));
    check("t1_read_n_idle", {31'd0, read_n}, 32'd1);

    // 2: three-cycle stall on the second read.
    s = iss_total;
    stall_addr = 32'h201;
    stall_left = 3;
    start_frame(32'h200);
    wait_done("t2_done");
    #1;
    check("t2_issued", 32'(iss_total - s), 32'(FW));
    check("t2_stall_used", 32'(stall_left), 32'd0);
    stall_addr = 32'hFFFF_FFFF;

    // 3: downstream stalled, credit limit.
    s = iss_total;
    pix_ready = 1'b0;
    start_frame(32'h300);
    repeat (30) @(posedge clk);
    #1;
    check("t3_credit_issued", 32'(iss_total - s), 32'(DEPTH));
    check("t3_read_n_held", {31'd0, read_n}, 32'd1);
    check("t3_pix_valid", {31'd0, pix_valid}, 32'd1);
    check("t3_pix_sof", {31'd0, pix_sof}, 32'd1);
    check("t3_pix_head", {16'd0, pix_data}, {16'd0, 16'h5A5A ^ 16'h0300});
    repeat (3) @(posedge clk);
    #1;
    check("t3_pix_hold", {16'd0, pix_data}, {16'd0, 16'h5A5A ^ 16'h0300});
    pix_ready = 1'b1;
    wait_done("t3_done");
    #1;
    check("t3_issued", 32'(iss_total - s), 32'(FW));
    check("t3_err", {31'd0, err_overflow}, 32'd0);

    // 4: stray return while idle.
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    @(posedge clk); #1;
    check("t4_err_set", {31'd0, err_overflow}, 32'd1);
    check("t4_stream_idle", {31'd0, pix_valid}, 32'd0);
    start_frame(32'h400);
    wait_done("t4_done");
    #1;
    check("t4_err_sticky", {31'd0, err_overflow}, 32'd1);

    // 6: start while busy and start coincident with done.
    s = iss_total;
    start_frame(32'h700);
    repeat (3) @(posedge clk);
    #1 frame_base = 32'h7F0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (pix_valid && pix_ready && pix_eof) begin
          seen = 1'b1;
          break;
        end
      end
      check("t6_eof_seen", {31'd0, seen}, 32'd1);
    end
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("t6_done_with_start", {31'd0, done}, 32'd1);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_issued", 32'(iss_total - s), 32'(FW));
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_read_n", {31'd0, read_n}, 32'd1);

    // 5: reset with three reads outstanding, then restart.
    s = iss_total;
    ret_hold = 1'b1;
    start_frame(32'h500);
    repeat (3) @(posedge clk);
    #1;
    check("t5_outstanding", 32'(iss_total - s), 32'd3);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    exp_addr.delete();
    exp_pix.delete();
    ret_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    start_frame(32'h600);
    @(negedge clk);
    check("t5_new_base", address, 32'h600);
    wait_done("t5_done");
    #1;
    check("t5_err_clean", {31'd0, err_overflow}, 32'd0);

    check("sb_addr_empty", 32'(exp_addr.size()), 32'd0);
    check("sb_pix_empty", 32'(exp_pix.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
